// File: rtl/cipher_frame_ctrl_if.sv
// Signal bundle between the frame sequencer and its UART, decrypt-core and display neighbours.
// master = sequencer side, slave = surrounding top-level side.
interface cipher_frame_ctrl_if;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [63:0] dec_in;
   logic        dec_start;
   logic [63:0] dec_out;
   logic [31:0] disp_data;
   logic        disp_en;
   logic        tx_en;
   logic [63:0] tx_data;
   logic        tx_busy;
   logic [15:0] frame_cnt;
   logic [7:0]  drop_cnt;
   // Test hook: presets frame_cnt to FFFF so counter wrap can be exercised quickly.
   logic        frame_cnt_load;

   modport master (
      input  rx_valid, rx_byte, dec_out, tx_busy, frame_cnt_load,
      output dec_in, dec_start, disp_data, disp_en, tx_en, tx_data, frame_cnt, drop_cnt
   );

   modport slave (
      output rx_valid, rx_byte, dec_out, tx_busy, frame_cnt_load,
      input  dec_in, dec_start, disp_data, disp_en, tx_en, tx_data, frame_cnt, drop_cnt
   );
endinterface

// File: rtl/cipher_frame_ctrl.sv
// Assembles 8 UART bytes into a cipher block, captures plaintext DEC_WAIT cycles later, optionally echoes it.
// Latency: capture at E+DEC_WAIT after the 8th byte; tx_en waits on tx_busy; bytes arriving outside COLLECT are dropped.
module cipher_frame_ctrl #(
   parameter int CLK_FREQ        = 100_000_000,
   parameter int BYTE_TIMEOUT_US = 1000,
   parameter int DEC_WAIT        = 2,
   parameter int ECHO            = 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   cipher_frame_ctrl_if.master bus
);

   localparam int TIMEOUT_CYC = CLK_FREQ / 1_000_000 * BYTE_TIMEOUT_US;
   localparam int TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      WAIT_LAST = 8'(DEC_WAIT - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DECRYPT = 2'd1,
      SEND    = 2'd2,
      TX_WAIT = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [55:0]     shreg;
   logic [2:0]      byte_cnt;
   logic [TO_W-1:0] to_cnt;
   logic [7:0]      wait_cnt;
   logic [1:0]      guard_cnt;
   logic [63:0]     result;
   logic [63:0]     dec_in_q;
   logic            dec_start_q;
   logic            disp_en_q;
   logic [15:0]     frame_cnt_q;
   logic [7:0]      drop_cnt_q;

   logic            accept_byte;
   logic            frame_done;
   logic            timeout_hit;
   logic            capture;
   logic            drop_byte;
   logic            tx_fire;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      accept_byte = 1'b0;
      frame_done  = 1'b0;
      timeout_hit = 1'b0;
      capture     = 1'b0;
      drop_byte   = 1'b0;
      tx_fire     = 1'b0;
      case (state)
         COLLECT: begin
            // An arriving byte takes precedence over a timeout expiring on the same edge.
            if (bus.rx_valid) begin
               accept_byte = 1'b1;
               if (byte_cnt == 3'd7) begin
                  frame_done = 1'b1;
                  state_nxt  = DECRYPT;
               end
            end else if (byte_cnt != 3'd0 && to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
            end
         end
         DECRYPT: begin
            drop_byte = bus.rx_valid;
            if (wait_cnt == WAIT_LAST) begin
               capture   = 1'b1;
               state_nxt = (ECHO != 0) ? SEND : COLLECT;
            end
         end
         SEND: begin
            drop_byte = bus.rx_valid;
            if (!bus.tx_busy) begin
               tx_fire   = 1'b1;
               state_nxt = TX_WAIT;
            end
         end
         TX_WAIT: begin
            drop_byte = bus.rx_valid;
            // tx_busy is only trusted after two guard cycles, giving the sender time to raise it.
            if (guard_cnt == 2'd2 && !bus.tx_busy) begin
               state_nxt = COLLECT;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         shreg       <= '0;
         byte_cnt    <= '0;
         to_cnt      <= '0;
         wait_cnt    <= '0;
         guard_cnt   <= '0;
         result      <= '0;
         dec_in_q    <= '0;
         dec_start_q <= 1'b0;
         disp_en_q   <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (accept_byte) begin
            shreg    <= {shreg[47:0], bus.rx_byte};
            byte_cnt <= byte_cnt + 3'd1;
            to_cnt   <= '0;
         end else if (timeout_hit) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
         end else if (state == COLLECT && byte_cnt != 3'd0) begin
            to_cnt <= to_cnt + TO_W'(1);
         end

         if (frame_done) begin
            dec_in_q <= {shreg, bus.rx_byte};
         end
         dec_start_q <= frame_done;

         if (state == DECRYPT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end

         if (state != TX_WAIT) begin
            guard_cnt <= '0;
         end else if (guard_cnt != 2'd2) begin
            guard_cnt <= guard_cnt + 2'd1;
         end

         if (capture) begin
            result      <= bus.dec_out;
            disp_en_q   <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (bus.frame_cnt_load) begin
            frame_cnt_q <= 16'hFFFF;
         end

         if ((drop_byte || timeout_hit) && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   assign bus.dec_in    = dec_in_q;
   assign bus.dec_start = dec_start_q;
   assign bus.disp_data = result[31:0];
   assign bus.disp_en   = disp_en_q;
   assign bus.tx_data   = result;
   assign bus.tx_en     = tx_fire;
   assign bus.frame_cnt = frame_cnt_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cipher_frame_ctrl.sv
// Directed bench for cipher_frame_ctrl: frame assembly, echo handshake, timeout, drops, reset and wrap.
// Decrypt core is modelled as bitwise inversion of dec_in.
module tb_cipher_frame_ctrl;

   logic sys_clk = 1'b0;
   logic sys_rst_n;

   cipher_frame_ctrl_if bus ();

   cipher_frame_ctrl #(
      .CLK_FREQ        (100_000_000),
      .BYTE_TIMEOUT_US (1),
      .DEC_WAIT        (2),
      .ECHO            (1)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   assign bus.dec_out = ~bus.dec_in;

   always #5 sys_clk = ~sys_clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc    = 0;
   int tx_cnt = 0;
   int ds_cnt = 0;
   int tx_last_cyc = -1;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (bus.tx_en === 1'b1) begin
         tx_cnt      <= tx_cnt + 1;
         tx_last_cyc <= cyc;
      end
      if (bus.dec_start === 1'b1) ds_cnt <= ds_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      step();
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] base);
      for (int i = 0; i < 8; i++) send_byte(base + 8'(i));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".dec_in"},    bus.dec_in, 64'h0);
      chk({tag, ".dec_start"}, 64'(bus.dec_start), 64'h0);
      chk({tag, ".disp_data"}, 64'(bus.disp_data), 64'h0);
      chk({tag, ".disp_en"},   64'(bus.disp_en), 64'h0);
      chk({tag, ".tx_en"},     64'(bus.tx_en), 64'h0);
      chk({tag, ".tx_data"},   bus.tx_data, 64'h0);
      chk({tag, ".frame_cnt"}, 64'(bus.frame_cnt), 64'h0);
      chk({tag, ".drop_cnt"},  64'(bus.drop_cnt), 64'h0);
   endtask

   initial begin
      int e;
      int tx0;
      int ds0;

      sys_rst_n          = 1'b0;
      bus.rx_valid       = 1'b0;
      bus.rx_byte        = 8'h00;
      bus.tx_busy        = 1'b0;
      bus.frame_cnt_load = 1'b0;
      repeat (3) step();
      chk_zero("reset");
      sys_rst_n = 1'b1;
      repeat (3) step();

      // Basic frame 01..08, tx_busy low.
      tx0 = tx_cnt;
      ds0 = ds_cnt;
      send_frame(8'h01);
      e = cyc;
      chk("basic.dec_in", bus.dec_in, 64'h0102030405060708);
      chk("basic.dec_start_hi", 64'(bus.dec_start), 64'h1);
      chk("basic.tx_en_E", 64'(bus.tx_en), 64'h0);
      step();
      chk("basic.dec_start_lo", 64'(bus.dec_start), 64'h0);
      chk("basic.frame_cnt_E1", 64'(bus.frame_cnt), 64'h0);
      step();
      chk("basic.tx_en_E2", 64'(bus.tx_en), 64'h1);
      chk("basic.tx_data", bus.tx_data, 64'hFEFDFCFBFAF9F8F7);
      chk("basic.disp_data", 64'(bus.disp_data), 64'hFAF9F8F7);
      chk("basic.frame_cnt", 64'(bus.frame_cnt), 64'h1);
      chk("basic.disp_en", 64'(bus.disp_en), 64'h1);
      repeat (10) step();
      chk("basic.tx_count", 64'(tx_cnt - tx0), 64'h1);
      chk("basic.tx_cycle", 64'(tx_last_cyc - e), 64'h2);
      chk("basic.dec_start_count", 64'(ds_cnt - ds0), 64'h1);

      // Busy back-pressure: tx_busy held for 50 cycles spanning capture.
      bus.tx_busy = 1'b1;
      tx0 = tx_cnt;
      send_frame(8'h21);
      for (int i = 0; i < 42; i++) begin
         chk("busy.tx_en_held", 64'(bus.tx_en), 64'h0);
         if (i >= 2) chk("busy.tx_data_stable", bus.tx_data, 64'hDEDDDCDBDAD9D8D7);
         step();
      end
      bus.tx_busy = 1'b0;
      #1;
      chk("busy.tx_en_release", 64'(bus.tx_en), 64'h1);
      step();
      chk("busy.tx_en_once", 64'(bus.tx_en), 64'h0);
      chk("busy.tx_data_after", bus.tx_data, 64'hDEDDDCDBDAD9D8D7);
      repeat (8) step();
      chk("busy.tx_count", 64'(tx_cnt - tx0), 64'h1);
      chk("busy.frame_cnt", 64'(bus.frame_cnt), 64'h2);

      // Timeout: three bytes then silence aborts at B+100.
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      repeat (99) step();
      chk("timeout.drop_before", 64'(bus.drop_cnt), 64'h0);
      step();
      chk("timeout.drop_after", 64'(bus.drop_cnt), 64'h1);
      send_frame(8'h11);
      chk("timeout.dec_in", bus.dec_in, 64'h1112131415161718);
      repeat (10) step();
      chk("timeout.frame_cnt", 64'(bus.frame_cnt), 64'h3);

      // rx_valid on the expiry edge is accepted.
      send_byte(8'h31);
      send_byte(8'h32);
      repeat (99) step();
      send_byte(8'h33);
      chk("prio.drop_same", 64'(bus.drop_cnt), 64'h1);
      for (int i = 0; i < 5; i++) send_byte(8'h34 + 8'(i));
      chk("prio.dec_in", bus.dec_in, 64'h3132333435363738);
      chk("prio.drop_after", 64'(bus.drop_cnt), 64'h1);
      repeat (10) step();

      // Drops while DECRYPT/SEND are busy.
      send_frame(8'h41);
      send_byte(8'hEE);
      chk("drop.cnt1", 64'(bus.drop_cnt), 64'h2);
      send_byte(8'hEF);
      chk("drop.cnt2", 64'(bus.drop_cnt), 64'h3);
      send_byte(8'hF0);
      chk("drop.cnt3", 64'(bus.drop_cnt), 64'h4);
      chk("drop.tx_data", bus.tx_data, 64'hBEBDBCBBBAB9B8B7);
      repeat (10) step();
      send_frame(8'h51);
      chk("drop.next_frame", bus.dec_in, 64'h5152535455565758);
      repeat (10) step();
      chk("drop.frame_cnt", 64'(bus.frame_cnt), 64'h6);

      // Saturation: hold rx_valid for 300 cycles while stuck in SEND.
      bus.tx_busy = 1'b1;
      send_frame(8'h61);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = 8'h99;
      repeat (250) step();
      chk("sat.fe", 64'(bus.drop_cnt), 64'hFE);
      step();
      chk("sat.ff", 64'(bus.drop_cnt), 64'hFF);
      repeat (49) step();
      chk("sat.hold", 64'(bus.drop_cnt), 64'hFF);
      bus.rx_valid = 1'b0;
      bus.tx_busy  = 1'b0;
      repeat (10) step();
      chk("sat.frame_cnt", 64'(bus.frame_cnt), 64'h7);

      // Reset during DECRYPT.
      send_frame(8'h71);
      sys_rst_n = 1'b0;
      tx0 = tx_cnt;
      step();
      chk_zero("midrst");
      sys_rst_n = 1'b1;
      repeat (20) step();
      chk("midrst.no_tx", 64'(tx_cnt - tx0), 64'h0);
      send_frame(8'h81);
      chk("midrst.dec_in", bus.dec_in, 64'h8182838485868788);
      repeat (2) step();
      chk("midrst.tx_en", 64'(bus.tx_en), 64'h1);
      chk("midrst.tx_data", bus.tx_data, 64'h7E7D7C7B7A797877);
      chk("midrst.frame_cnt", 64'(bus.frame_cnt), 64'h1);
      repeat (10) step();

      // frame_cnt wrap via preset hook.
      bus.frame_cnt_load = 1'b1;
      step();
      bus.frame_cnt_load = 1'b0;
      chk("wrap.preset", 64'(bus.frame_cnt), 64'hFFFF);
      send_frame(8'h91);
      repeat (2) step();
      chk("wrap.frame_cnt", 64'(bus.frame_cnt), 64'h0);
      chk("wrap.disp_data", 64'(bus.disp_data), 64'h6A696867);
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
